// File: rtl/regbank_write_ctrl.sv
// Two-requester write arbiter for an 8x16 register bank, with a busy scoreboard and power-up bank clear.
// Grants are combinational and the bank write follows one cycle later; a requester that is not granted holds its request.
module regbank_write_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [2:0]  a_addr,
    input  logic [15:0] a_data,
    output logic        a_gnt,
    input  logic        b_req,
    input  logic [2:0]  b_addr,
    input  logic [15:0] b_data,
    output logic        b_gnt,
    input  logic        rsv_valid,
    input  logic [2:0]  rsv_addr,
    output logic        rsv_ok,
    output logic [7:0]  busy,
    output logic [7:0]  enable,
    output logic [15:0] destination_data,
    output logic        init_done
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [7:0]  enable_q, enable_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  busy_q, busy_d;
    logic        init_done_q, init_done_d;
    logic        last_b_q, last_b_d;   // 1 when B held the most recent grant

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= 3'd0;
            enable_q    <= 8'h00;
            data_q      <= 16'h0000;
            busy_q      <= 8'h00;
            init_done_q <= 1'b0;
            last_b_q    <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            enable_q    <= enable_d;
            data_q      <= data_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
            last_b_q    <= last_b_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        enable_d    = 8'h00;
        data_d      = data_q;
        busy_d      = busy_q;
        init_done_d = init_done_q;
        last_b_d    = last_b_q;
        a_gnt       = 1'b0;
        b_gnt       = 1'b0;
        rsv_ok      = 1'b0;

        if (state_q == INIT) begin
            enable_d = 8'h01 << cnt_q;
            data_d   = 16'h0000;
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                state_d     = RUN;
                init_done_d = 1'b1;
            end
        end else begin
            a_gnt  = a_req & (~b_req | last_b_q);
            b_gnt  = b_req & ~a_gnt;
            rsv_ok = rsv_valid & ~busy_q[rsv_addr];

            if (a_gnt) begin
                enable_d       = 8'h01 << a_addr;
                data_d         = a_data;
                busy_d[a_addr] = 1'b0;
                last_b_d       = 1'b0;
            end else if (b_gnt) begin
                enable_d       = 8'h01 << b_addr;
                data_d         = b_data;
                busy_d[b_addr] = 1'b0;
                last_b_d       = 1'b1;
            end

            // A release of a busy register blocks its reservation through rsv_ok, so this set only lands on free registers.
            if (rsv_ok) begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
    end

    assign busy             = busy_q;
    assign enable           = enable_q;
    assign destination_data = data_q;
    assign init_done        = init_done_q;

endmodule

// File: doc/regbank_write_ctrl.md
REGBANK_WRITE_CTRL -- requirements
Module: regbank_write_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  requester A (ALU writeback) write request.
- a_addr  in  3  requester A destination register index.
- a_data  in  16  requester A write data.
- a_gnt  out  1  requester A granted; A's data is consumed at this clock edge.
- b_req  in  1  requester B (load unit) write request.
- b_addr  in  3  requester B destination register index.
- b_data  in  16  requester B write data.
- b_gnt  out  1  requester B granted; B's data is consumed at this clock edge.
- rsv_valid  in  1  issue stage requests a reservation of register rsv_addr.
- rsv_addr  in  3  index of the register to reserve.
- rsv_ok  out  1  reservation accepted this cycle.
- busy  out  8  scoreboard; bit i set means register i has a write pending.
- enable  out  8  one-hot write enable to the 8x16 register bank.
- destination_data  out  16  write data to the register bank.
- init_done  out  1  bank clear sequence complete.

Function
REQ-003 The FSM SHALL have exactly two states: INIT and RUN.
REQ-004 INIT SHALL clear the bank: on each cycle with counter cnt[2:0], register enable = one-hot(cnt) and destination_data = 16'h0000 for the next cycle, then increment cnt.
REQ-005 When cnt = 7 in INIT, the FSM SHALL move to RUN; init_done SHALL go to 1 on the same edge and stay 1 until reset.
REQ-006 In INIT, a_gnt, b_gnt and rsv_ok SHALL be 0.
REQ-007 In RUN, a_gnt and b_gnt SHALL be combinational from a_req, b_req and the round-robin pointer, and SHALL never both be 1.
REQ-008 In RUN, with only one requester active, that requester SHALL be granted.
REQ-009 In RUN, with both requesters active, the requester not granted last SHALL be granted.
REQ-010 The round-robin pointer SHALL update only on a grant.
REQ-011 A grant SHALL produce, on the next cycle, enable = one-hot(granted addr) and destination_data = granted data, for exactly one cycle (1-cycle latency).
REQ-012 In RUN with no grant, the next-cycle enable SHALL be 8'h00; destination_data SHALL hold its last value.
REQ-013 A requester not granted SHALL keep its request and its signals stable until granted; the block SHALL not buffer requests.
REQ-014 If both requesters target the same addr, they SHALL be serialized by round-robin, and both writes SHALL reach the bank in grant order.
REQ-015 rsv_ok SHALL equal rsv_valid AND (state == RUN) AND NOT busy[rsv_addr], combinationally.
REQ-016 On rsv_ok, busy[rsv_addr] SHALL be set at the clock edge.
REQ-017 A grant to addr k SHALL clear busy[k] at the grant edge.
REQ-018 A write to a non-busy register SHALL be allowed and SHALL leave busy unchanged.
REQ-019 With simultaneous release of addr k and reservation of addr k while busy[k] = 1, rsv_ok SHALL be 0 and busy[k] SHALL clear.
REQ-020 Reservation of addr j and release of addr k (j != k) in the same cycle SHALL both take effect.

Reset
REQ-021 While rst_n = 0, the block SHALL hold: state = INIT, cnt = 0, enable = 8'h00, destination_data = 16'h0000, busy = 8'h00, init_done = 0, and the round-robin pointer = B, so that A wins the first tie.
REQ-022 The first INIT enable SHALL appear in the first cycle after rst_n deasserts.
REQ-023 Reset asserted mid-INIT or mid-RUN SHALL abort immediately and discard any in-flight write, and the block SHALL restart INIT after release.

Verification
REQ-024 Reset release, no requests -> enable = 01,02,04,...,80 on 8 consecutive cycles with data 0000, init_done = 1 afterwards, then enable = 00.
REQ-025 RUN, a_req = 1 with addr 3 and data 1234 for one cycle -> a_gnt = 1 that cycle; next cycle enable = 08 and data = 1234; following cycle enable = 00.
REQ-026 RUN, a_req and b_req held high for 4 cycles (A addr 1 data AAAA, B addr 2 data BBBB) -> grants A,B,A,B; enable = 02,04,02,04 one cycle later.
REQ-027 rsv_valid with addr 5 -> rsv_ok = 1 and busy = 20; rsv_valid with addr 5 again -> rsv_ok = 0; b_req addr 5 granted -> busy = 00.
REQ-028 busy[4] = 1, with rsv_valid addr 4 and a grant to addr 4 in the same cycle -> rsv_ok = 0 and busy[4] = 0 after the edge.
REQ-029 rst_n pulsed low during RUN with a pending grant -> no enable pulse for the aborted write, busy = 00, and the INIT sweep repeats.
